// File: rtl/uart_baudgen_frac.sv
// Fractional-N UART baud generator: a phase accumulator produces the oversample strobe,
// and an oversample counter derives the bit strobe and the clkUtx square wave.
module uart_baudgen_frac #(
  parameter int unsigned ACC_W   = 16,
  parameter int unsigned OVS     = 16,
  parameter int unsigned INC_RST = 12080
) (
  input  logic             clk10mhz,
  input  logic             rst_n,
  input  logic             en,
  input  logic             restart,
  input  logic [ACC_W-1:0] inc,
  input  logic             inc_ld,
  output logic             ovs_tick,
  output logic             tx_tick,
  output logic             clkUtx,
  output logic             inc_pend
);

  localparam int unsigned     CntW    = (OVS > 1) ? $clog2(OVS) : 1;
  localparam logic [CntW-1:0] CntMax  = CntW'(OVS - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(OVS / 2);
  localparam logic [ACC_W-1:0] IncRst = ACC_W'(INC_RST);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] inc_q;
  logic [ACC_W-1:0] inc_nxt;
  logic [CntW-1:0]  ovs_cnt;

  logic [ACC_W:0]   sum;
  logic [CntW-1:0]  cnt_nxt;
  logic             carry;
  logic             wrap;
  logic             apply;

  always_comb begin
    sum     = {1'b0, acc} + {1'b0, inc_q};
    carry   = en & ~restart & sum[ACC_W];
    wrap    = carry & (ovs_cnt == CntMax);
    cnt_nxt = ovs_cnt;
    if (carry) begin
      cnt_nxt = wrap ? '0 : ovs_cnt + CntW'(1);
    end
    // A pending rate change lands only on a bit boundary or a phase realign.
    apply   = inc_pend & (restart | wrap);
  end

  always_ff @(posedge clk10mhz or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      inc_q    <= IncRst;
      inc_nxt  <= '0;
      ovs_cnt  <= '0;
      inc_pend <= 1'b0;
      ovs_tick <= 1'b0;
      tx_tick  <= 1'b0;
      clkUtx   <= 1'b0;
    end else begin
      if (restart) begin
        acc      <= '0;
        ovs_cnt  <= '0;
        clkUtx   <= 1'b0;
        ovs_tick <= 1'b0;
        tx_tick  <= 1'b0;
      end else if (en) begin
        acc      <= sum[ACC_W-1:0];
        ovs_cnt  <= cnt_nxt;
        ovs_tick <= carry;
        tx_tick  <= wrap;
        clkUtx   <= (cnt_nxt >= CntHalf);
      end else begin
        ovs_tick <= 1'b0;
        tx_tick  <= 1'b0;
      end

      // A load arriving on the applying boundary wins over the older pending value.
      if (apply) begin
        inc_q    <= inc_ld ? inc : inc_nxt;
        inc_pend <= 1'b0;
      end else if (inc_ld) begin
        if (en) begin
          inc_nxt  <= inc;
          inc_pend <= 1'b1;
        end else begin
          inc_q <= inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_baudgen_frac.sv
// Directed bench for uart_baudgen_frac: rates, deferred/idle loads, restart, freeze and reset.
module tb_uart_baudgen_frac;

  logic        clk10mhz = 1'b0;
  logic        rst_n    = 1'b0;
  logic        en       = 1'b0;
  logic        restart  = 1'b0;
  logic        inc_ld   = 1'b0;
  logic [15:0] inc      = '0;
  logic        ovs_tick;
  logic        tx_tick;
  logic        clkUtx;
  logic        inc_pend;

  int n_checks = 0;
  int n_fail   = 0;

  uart_baudgen_frac #(
    .ACC_W  (16),
    .OVS    (16),
    .INC_RST(12080)
  ) dut (
    .clk10mhz(clk10mhz),
    .rst_n   (rst_n),
    .en      (en),
    .restart (restart),
    .inc     (inc),
    .inc_ld  (inc_ld),
    .ovs_tick(ovs_tick),
    .tx_tick (tx_tick),
    .clkUtx  (clkUtx),
    .inc_pend(inc_pend)
  );

  always #5 clk10mhz = ~clk10mhz;

  task automatic step();
    @(posedge clk10mhz);
    #1;
  endtask

  task automatic wait_tx(output int cycles);
    cycles = -1;
    for (int i = 1; i <= 1000; i++) begin
      step();
      if (tx_tick === 1'b1) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if (ovs_tick !== 1'b0) begin n_fail++; $display("FAIL reset_ovs_tick: got %b want 0", ovs_tick); end
    n_checks++;
    if (tx_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tx_tick: got %b want 0", tx_tick); end
    n_checks++;
    if (clkUtx !== 1'b0) begin n_fail++; $display("FAIL reset_clkUtx: got %b want 0", clkUtx); end
    n_checks++;
    if (inc_pend !== 1'b0) begin n_fail++; $display("FAIL reset_inc_pend: got %b want 0", inc_pend); end
    rst_n = 1'b1;
  endtask

  task automatic test_default_rate();
    int ovs_n = 0, tx_n = 0, hi_n = 0, bad_ovs = 0, bad_tx = 0, orphan = 0;
    int last_ovs = -1, last_tx = -1;
    en = 1'b1;
    for (int i = 1; i <= 65536; i++) begin
      step();
      if (ovs_tick === 1'b1) begin
        if (last_ovs >= 0 && (i - last_ovs) != 5 && (i - last_ovs) != 6) bad_ovs++;
        last_ovs = i;
        ovs_n++;
        if (clkUtx === 1'b1) hi_n++;
      end
      if (tx_tick === 1'b1) begin
        if (last_tx >= 0 && (i - last_tx) != 86 && (i - last_tx) != 87) bad_tx++;
        last_tx = i;
        tx_n++;
        if (ovs_tick !== 1'b1) orphan++;
      end
    end
    n_checks++;
    if (ovs_n != 12080) begin n_fail++; $display("FAIL default_ovs_count: got %0d want 12080", ovs_n); end
    n_checks++;
    if (tx_n != 755) begin n_fail++; $display("FAIL default_tx_count: got %0d want 755", tx_n); end
    n_checks++;
    if (bad_ovs != 0) begin n_fail++; $display("FAIL default_ovs_gaps: got %0d bad want 0", bad_ovs); end
    n_checks++;
    if (bad_tx != 0) begin n_fail++; $display("FAIL default_tx_gaps: got %0d bad want 0", bad_tx); end
    n_checks++;
    if (hi_n != 6040) begin n_fail++; $display("FAIL default_clk_high: got %0d want 6040", hi_n); end
    n_checks++;
    if (orphan != 0) begin n_fail++; $display("FAIL default_tx_subset: got %0d want 0", orphan); end
  endtask

  task automatic test_deferred_load();
    int seen = 0, pend_bad = 0, gap;
    bit found = 1'b0;
    for (int i = 0; i < 100 && seen < 3; i++) begin
      step();
      if (ovs_tick === 1'b1) seen++;
    end
    inc    = 16'd6040;
    inc_ld = 1'b1;
    step();
    inc_ld = 1'b0;
    n_checks++;
    if (inc_pend !== 1'b1) begin n_fail++; $display("FAIL defer_pend_set: got %b want 1", inc_pend); end
    for (int i = 0; i < 400; i++) begin
      step();
      if (tx_tick === 1'b1) begin
        found = 1'b1;
        break;
      end
      if (inc_pend !== 1'b1) pend_bad++;
    end
    n_checks++;
    if (!found || pend_bad != 0) begin
      n_fail++;
      $display("FAIL defer_pend_hold: found %b bad %0d want found 1 bad 0", found, pend_bad);
    end
    n_checks++;
    if (inc_pend !== 1'b0) begin n_fail++; $display("FAIL defer_pend_clear: got %b want 0", inc_pend); end
    for (int k = 0; k < 4; k++) begin
      wait_tx(gap);
      n_checks++;
      if (gap != 173 && gap != 174) begin
        n_fail++;
        $display("FAIL defer_tx_gap%0d: got %0d want 173 or 174", k, gap);
      end
    end
  endtask

  task automatic test_idle_load();
    int gap;
    en = 1'b0;
    step();
    n_checks++;
    if (ovs_tick !== 1'b0 || tx_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_ticks: got ovs %b tx %b want 0 0", ovs_tick, tx_tick);
    end
    inc    = 16'd24159;
    inc_ld = 1'b1;
    step();
    inc_ld = 1'b0;
    n_checks++;
    if (inc_pend !== 1'b0) begin n_fail++; $display("FAIL idle_pend: got %b want 0", inc_pend); end
    en = 1'b1;
    wait_tx(gap);
    for (int k = 0; k < 4; k++) begin
      wait_tx(gap);
      n_checks++;
      if (gap != 43 && gap != 44) begin
        n_fail++;
        $display("FAIL idle_tx_gap%0d: got %0d want 43 or 44", k, gap);
      end
    end
  endtask

  task automatic test_restart();
    int gap, seen = 0, ovs_num = 0, first_at = -1, tx_at = -1;
    en     = 1'b0;
    inc    = 16'd12080;
    inc_ld = 1'b1;
    step();
    inc_ld = 1'b0;
    en     = 1'b1;
    wait_tx(gap);
    for (int i = 0; i < 200 && seen < 11; i++) begin
      step();
      if (ovs_tick === 1'b1) seen++;
    end
    n_checks++;
    if (clkUtx !== 1'b1) begin n_fail++; $display("FAIL restart_pre_clk: got %b want 1", clkUtx); end
    restart = 1'b1;
    step();
    restart = 1'b0;
    n_checks++;
    if (clkUtx !== 1'b0 || ovs_tick !== 1'b0 || tx_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_clear: got clk %b ovs %b tx %b want 0 0 0", clkUtx, ovs_tick, tx_tick);
    end
    for (int i = 1; i <= 200; i++) begin
      step();
      if (ovs_tick === 1'b1) begin
        ovs_num++;
        if (ovs_num == 1) first_at = i;
      end
      if (tx_tick === 1'b1) begin
        tx_at = ovs_num;
        break;
      end
    end
    n_checks++;
    if (first_at != 6) begin n_fail++; $display("FAIL restart_first_ovs: got %0d want 6", first_at); end
    n_checks++;
    if (tx_at != 16) begin n_fail++; $display("FAIL restart_first_tx: got %0d want 16", tx_at); end
  endtask

  task automatic test_freeze_zero_inc();
    logic saved;
    int bad = 0, resume_at = -1;
    restart = 1'b1;
    step();
    restart = 1'b0;
    for (int i = 0; i < 3; i++) step();
    en    = 1'b0;
    saved = clkUtx;
    for (int i = 0; i < 100; i++) begin
      step();
      if (ovs_tick !== 1'b0 || tx_tick !== 1'b0 || clkUtx !== saved) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL freeze_hold: got %0d bad cycles want 0", bad); end
    en = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      step();
      if (ovs_tick === 1'b1) begin
        resume_at = i;
        break;
      end
    end
    n_checks++;
    if (resume_at != 3) begin n_fail++; $display("FAIL freeze_phase: got %0d want 3", resume_at); end
    en     = 1'b0;
    inc    = 16'd0;
    inc_ld = 1'b1;
    step();
    inc_ld = 1'b0;
    en     = 1'b1;
    saved  = clkUtx;
    bad    = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (ovs_tick !== 1'b0 || tx_tick !== 1'b0 || clkUtx !== saved) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL zero_inc_hold: got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_async_reset();
    int ovs_num = 0, first_at = -1, second_at = -1;
    inc    = 16'd6040;
    inc_ld = 1'b1;
    step();
    inc_ld = 1'b0;
    n_checks++;
    if (inc_pend !== 1'b1) begin n_fail++; $display("FAIL arst_pend_set: got %b want 1", inc_pend); end
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ovs_tick, tx_tick, clkUtx, inc_pend} !== 4'b0000) begin
      n_fail++;
      $display("FAIL arst_outputs: got %b want 0000", {ovs_tick, tx_tick, clkUtx, inc_pend});
    end
    #2;
    rst_n = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (ovs_tick === 1'b1) begin
        ovs_num++;
        if (ovs_num == 1) first_at = i;
        if (ovs_num == 2) begin
          second_at = i;
          break;
        end
      end
    end
    n_checks++;
    if (first_at != 6) begin n_fail++; $display("FAIL arst_first_ovs: got %0d want 6", first_at); end
    n_checks++;
    if (second_at != 11) begin n_fail++; $display("FAIL arst_second_ovs: got %0d want 11", second_at); end
    n_checks++;
    if (inc_pend !== 1'b0) begin n_fail++; $display("FAIL arst_pend_after: got %b want 0", inc_pend); end
  endtask

  initial begin
    test_reset();
    test_default_rate();
    test_deferred_load();
    test_idle_load();
    test_restart();
    test_freeze_zero_inc();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
